// File: rtl/count_stepper.sv
// count_stepper: drives a loadable mod-MODULUS up/down counter to requested positions by jump or shortest-path stepping
module count_stepper #(
  parameter int MODULUS = 12,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_mode,
  output logic             cnt_load,
  output logic             cnt_up_down,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic             sync_err
);
  typedef enum logic [1:0] {IDLE, LOAD, STEP} state_t;
  localparam logic [WIDTH:0] M = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d, rem_q, rem_d;
  logic dir_q, dir_d, done_q, done_d, rerr_q, rerr_d, serr_q, serr_d, first_q, busy_q;
  logic [WIDTH:0] tgt, cur, dist_up, dist_dn;
  logic up;
  assign tgt = {1'b0, req_target};
  assign cur = {1'b0, pos_q};
  assign dist_up = tgt >= cur ? tgt - cur : tgt + M - cur;
  assign dist_dn = cur >= tgt ? cur - tgt : cur + M - tgt;
  assign up = dist_up <= dist_dn;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b1;
      done_q <= 1'b0;
      rerr_q <= 1'b0;
      serr_q <= 1'b0;
      first_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
      done_q <= done_d;
      rerr_q <= rerr_d;
      serr_q <= serr_d;
      first_q <= 1'b0;
      busy_q <= state_d != IDLE;
    end
  end
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    rem_d = rem_q;
    dir_d = dir_q;
    done_d = 1'b0;
    rerr_d = 1'b0;
    serr_d = serr_q | (state_q == IDLE && !first_q && cnt_value != pos_q);
    if (state_q == IDLE && req_valid) begin
      if (tgt >= M) rerr_d = 1'b1;
      else if (req_mode) begin
        pos_d = req_target;
        state_d = LOAD;
      end else if (dist_up == '0) done_d = 1'b1;
      else begin
        dir_d = up;
        rem_d = up ? dist_up[WIDTH-1:0] : dist_dn[WIDTH-1:0];
        state_d = STEP;
      end
    end else if (state_q == LOAD) begin
      state_d = IDLE;
      done_d = 1'b1;
    end else if (state_q == STEP) begin
      pos_d = dir_q ? (pos_q == TOP ? '0 : pos_q + 1'b1) : (pos_q == '0 ? TOP : pos_q - 1'b1);
      rem_d = rem_q - 1'b1;
      if (rem_q == WIDTH'(1)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  assign req_ready = state_q == IDLE;
  assign cnt_load = state_q != STEP;
  assign cnt_up_down = state_q == STEP ? dir_q : 1'b1;
  assign cnt_data = pos_q;
  assign busy = busy_q;
  assign done = done_q;
  assign range_err = rerr_q;
  assign sync_err = serr_q;
endmodule

// File: tb/tb_count_stepper.sv
// tb_count_stepper: randomized and directed check of count_stepper against a transaction-level model
module tb_count_stepper;
  localparam int M = 12;
  logic clk = 0, reset = 1, req_valid = 0, req_mode = 0;
  logic [3:0] req_target = '0;
  logic req_ready, cnt_load, cnt_up_down, busy, done, range_err, sync_err;
  logic [3:0] cnt_data, cnt_value, cnt, force_val = '0;
  logic force_en = 0;
  int checks = 0, failures = 0;
  typedef struct {bit ld; bit ud; bit busy; bit done; bit rerr; bit cd; bit [3:0] data;} rec_t;
  rec_t q[$];
  rec_t cur_r;
  int m_pos = 0;
  bit m_serr = 0, m_first = 1, run = 0;

  count_stepper #(.MODULUS(12), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_mode(req_mode), .cnt_load(cnt_load),
    .cnt_up_down(cnt_up_down), .cnt_data(cnt_data), .cnt_value(cnt_value),
    .busy(busy), .done(done), .range_err(range_err), .sync_err(sync_err));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset) cnt <= '0;
    else if (cnt_load) cnt <= cnt_data;
    else cnt <= cnt_up_down ? (cnt == 4'(M-1) ? 4'd0 : cnt + 4'd1) : (cnt == 4'd0 ? 4'(M-1) : cnt - 4'd1);
  assign cnt_value = force_en ? force_val : cnt;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", n, a, e, $time);
    end
  endtask

  function automatic rec_t mk(bit ld, bit ud, bit b, bit d, bit r, bit cd, int data);
    rec_t x;
    x.ld = ld; x.ud = ud; x.busy = b; x.done = d; x.rerr = r; x.cd = cd; x.data = 4'(data);
    return x;
  endfunction

  task automatic accept(int t, bit jump);
    int p, du, dd, d;
    bit up;
    p = m_pos;
    if (t >= M) q.push_back(mk(1, 1, 0, 0, 1, 1, p));
    else if (jump) begin
      q.push_back(mk(1, 1, 1, 0, 0, 1, t));
      q.push_back(mk(1, 1, 0, 1, 0, 1, t));
      m_pos = t;
    end else begin
      du = (t - p + M) % M;
      dd = (p - t + M) % M;
      up = du <= dd;
      d = up ? du : dd;
      for (int k = 0; k < d; k++) q.push_back(mk(0, up, 1, 0, 0, 0, 0));
      q.push_back(mk(1, 1, 0, 1, 0, 1, t));
      m_pos = t;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_pos = 0;
      m_serr = 0;
      m_first = 1;
      cur_r = mk(1, 1, 0, 0, 0, 1, 0);
      run = 1;
    end else begin
      if (!cur_r.busy && !m_first && int'(cnt_value) != m_pos) m_serr = 1;
      m_first = 0;
      if (!cur_r.busy && req_valid) accept(int'(req_target), req_mode);
      cur_r = q.size() > 0 ? q.pop_front() : mk(1, 1, 0, 0, 0, 1, m_pos);
    end
  end

  always @(negedge clk) if (run) begin
    chk("cnt_load", cnt_load, cur_r.ld);
    chk("cnt_up_down", cnt_up_down, cur_r.ud);
    chk("busy", busy, cur_r.busy);
    chk("req_ready", req_ready, !cur_r.busy);
    chk("done", done, cur_r.done);
    chk("range_err", range_err, cur_r.rerr);
    chk("sync_err", sync_err, m_serr);
    if (cur_r.cd) chk("cnt_data", cnt_data, cur_r.data);
    if (!cur_r.busy && !force_en) chk("cnt_value", cnt_value, m_pos);
  end

  task automatic do_req(int t, bit m, output int lat, output int steps, output int ups,
                        output int ldd, output bit gd, output bit gr, output int cv);
    lat = 0; steps = 0; ups = 0; ldd = -1; gd = 0; gr = 0; cv = -1;
    req_valid = 1; req_target = 4'(t); req_mode = m;
    @(posedge clk); #2;
    req_valid = 0;
    while (lat < 40 && !gd && !gr) begin
      @(negedge clk);
      lat++;
      if (!cnt_load) begin steps++; ups += int'(cnt_up_down); end
      if (busy && cnt_load) ldd = int'(cnt_data);
      if (done) begin gd = 1; cv = int'(cnt_value); end
      if (range_err) gr = 1;
    end
  endtask

  initial begin
    int lat, steps, ups, ldd, cv;
    bit gd, gr, dn;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    repeat (5) @(negedge clk);
    chk("idle_load", cnt_load, 1);
    chk("idle_data", cnt_data, 0);
    chk("idle_value", cnt_value, 0);
    chk("idle_sync", sync_err, 0);
    do_req(6, 0, lat, steps, ups, ldd, gd, gr, cv);
    chk("s06_steps", steps, 6); chk("s06_ups", ups, 6); chk("s06_done", gd, 1);
    chk("s06_lat", lat, 7); chk("s06_value", cv, 6);
    do_req(2, 1, lat, steps, ups, ldd, gd, gr, cv);
    do_req(9, 0, lat, steps, ups, ldd, gd, gr, cv);
    chk("s29_steps", steps, 5); chk("s29_ups", ups, 0); chk("s29_value", cv, 9);
    do_req(3, 1, lat, steps, ups, ldd, gd, gr, cv);
    chk("j93_lat", lat, 2); chk("j93_ldata", ldd, 3); chk("j93_steps", steps, 0); chk("j93_value", cv, 3);
    do_req(13, 0, lat, steps, ups, ldd, gd, gr, cv);
    chk("r13_err", gr, 1); chk("r13_done", gd, 0); chk("r13_value", cnt_value, 3); chk("r13_data", cnt_data, 3);
    do_req(3, 0, lat, steps, ups, ldd, gd, gr, cv);
    chk("same_lat", lat, 1); chk("same_steps", steps, 0); chk("same_done", gd, 1);
    do_req(0, 1, lat, steps, ups, ldd, gd, gr, cv);
    req_valid = 1; req_target = 4'd5; req_mode = 0;
    @(posedge clk); #2 req_valid = 0;
    repeat (3) @(negedge clk);
    chk("abort_stepping", cnt_load, 0);
    reset = 1;
    @(posedge clk); #2 reset = 0;
    dn = 0;
    repeat (8) begin @(negedge clk); dn |= done; end
    chk("abort_done", dn, 0); chk("abort_data", cnt_data, 0); chk("abort_busy", busy, 0);
    do_req(3, 1, lat, steps, ups, ldd, gd, gr, cv);
    force_val = 4'd7; force_en = 1;
    repeat (3) @(negedge clk);
    chk("force_sync", sync_err, 1);
    force_en = 0;
    repeat (4) @(negedge clk);
    chk("sticky_sync", sync_err, 1);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    @(negedge clk);
    chk("cleared_sync", sync_err, 0);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      reset = ($urandom % 250) == 0;
      req_valid = ($urandom % 3) == 0;
      req_target = 4'($urandom % 16);
      req_mode = 1'($urandom % 2);
    end
    @(posedge clk); #2 reset = 0; req_valid = 0;
    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
